// File: rtl/m2vpkg.sv
// Shared definitions for the MPEG-2 block pipeline: blocks per macroblock and
// the {coded, index} tag carried through the ISDQ/IDCT/MC tag FIFOs.
package m2vpkg;

  localparam int         BLK_PER_MB = 6;
  localparam logic [2:0] LAST_BLK   = 3'(BLK_PER_MB - 1);

  typedef struct packed {
    logic       coded;
    logic [2:0] idx;
  } blk_tag_t;

endpackage

// File: rtl/m2vblkseq_fifo.sv
// In-order block tag FIFO; the head is visible combinationally (zero when empty)
// so start pulses can present their tag in the same cycle.
module m2vblkseq_fifo
  import m2vpkg::*;
#(
  parameter int DEPTH = 2,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  blk_tag_t      din,
  output blk_tag_t      dout,
  output logic [LW-1:0] level
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  blk_tag_t      mem [DEPTH];
  logic [PW-1:0] rd_ptr_reg, wr_ptr_reg;
  logic          do_push, do_pop;

  // A push into a full FIFO is only taken when a pop frees the slot in the same cycle.
  assign do_pop  = pop && (level != '0);
  assign do_push = push && ((level != LW'(DEPTH)) || do_pop);

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      level      <= '0;
    end else if (clr) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      level      <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= bump(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= bump(rd_ptr_reg);
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  assign dout = (level != '0) ? mem[rd_ptr_reg] : '0;

endmodule

// File: rtl/m2vblkseq.sv
// Block-level sequencer tracking six blocks per macroblock through ISDQ, IDCT and MC.
// Define M2VBLKSEQ_ERRCHK_EN to enable the sticky protocol error flag and event filtering.
module m2vblkseq
  import m2vpkg::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       softreset,
  input  logic       mb_valid,
  input  logic [5:0] mb_cbp,
  input  logic       mb_intra,
  output logic       mb_ready,
  output logic [2:0] s1_block,
  output logic       s1_coded,
  input  logic       block_start,
  input  logic       block_end,
  input  logic       picture_complete,
  input  logic       isdq_done,
  input  logic       idct_done,
  input  logic       mc_done,
  output logic       ready_isdq,
  output logic       ready_idct,
  output logic       ready_mc,
  output logic       idct_start,
  output logic [3:0] idct_block,
  output logic       mc_start,
  output logic [3:0] mc_block,
  output logic       mc_mb_last,
  output logic       picture_done,
  output logic       err
);

  localparam int         CW      = $clog2(BUF_DEPTH + 1);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BLK  = 1'b1;

  logic [0:0]    state_reg, state_next;
  logic [2:0]    idx_reg, idx_next;
  logic [5:0]    cbp_reg;
  logic          intra_reg;
  logic [CW-1:0] dn_isdq_reg, dn_idct_reg;
  logic          pic_pend_reg, pic_pend_next;
  logic          in_blk, mb_accept;
  logic          ev_bs, ev_be, ev_isdq, ev_idct, ev_mc;

  blk_tag_t      fifo_din  [3];
  blk_tag_t      fifo_head [3];
  logic [CW-1:0] fifo_lv   [3];
  logic [2:0]    fifo_push, fifo_pop;

  assign in_blk    = (state_reg == ST_BLK);
  assign mb_ready  = !in_blk;
  assign mb_accept = mb_valid && mb_ready;
  assign s1_block  = idx_reg;
  assign s1_coded  = in_blk && (intra_reg || cbp_reg[LAST_BLK - idx_reg]);

  assign ready_isdq = fifo_lv[0] < CW'(BUF_DEPTH);
  assign ready_idct = fifo_lv[1] < CW'(BUF_DEPTH);
  assign ready_mc   = fifo_lv[2] < CW'(BUF_DEPTH);

  assign idct_start = (dn_isdq_reg != '0) && ready_idct;
  assign mc_start   = (dn_idct_reg != '0) && ready_mc;
  assign idct_block = fifo_head[0];
  assign mc_block   = fifo_head[1];
  assign mc_mb_last = mc_start && (fifo_head[1].idx == LAST_BLK);

`ifdef M2VBLKSEQ_ERRCHK_EN
  logic err_reg;
  logic err_bs, err_be, err_isdq, err_idct, err_mc;

  assign err_bs   = block_start && (!ready_isdq || !in_blk);
  assign err_be   = block_end && !in_blk;
  assign err_isdq = isdq_done && (dn_isdq_reg == fifo_lv[0]);
  assign err_idct = idct_done && (dn_idct_reg == fifo_lv[1]);
  assign err_mc   = mc_done && (fifo_lv[2] == '0);

  assign ev_bs   = block_start && !err_bs;
  assign ev_be   = block_end && !err_be;
  assign ev_isdq = isdq_done && !err_isdq;
  assign ev_idct = idct_done && !err_idct;
  assign ev_mc   = mc_done && !err_mc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        err_reg <= 1'b0;
    else if (softreset)  err_reg <= 1'b0;
    else if (err_bs || err_be || err_isdq || err_idct || err_mc) err_reg <= 1'b1;
  end

  assign err = err_reg;
`else
  assign ev_bs   = block_start;
  assign ev_be   = block_end && in_blk;
  assign ev_isdq = isdq_done;
  assign ev_idct = idct_done;
  assign ev_mc   = mc_done;
  assign err     = 1'b0;
`endif

  // Tags move A -> B on idct_start and B -> C on mc_start.
  assign fifo_din[0] = '{coded: s1_coded, idx: s1_block};
  assign fifo_din[1] = fifo_head[0];
  assign fifo_din[2] = fifo_head[1];
  assign fifo_push   = {mc_start, idct_start, ev_bs};
  assign fifo_pop    = {ev_mc, mc_start, idct_start};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_fifo
      m2vblkseq_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (softreset),
        .push    (fifo_push[gi]),
        .pop     (fifo_pop[gi]),
        .din     (fifo_din[gi]),
        .dout    (fifo_head[gi]),
        .level   (fifo_lv[gi])
      );
    end
  endgenerate

  assign picture_done = pic_pend_reg && !in_blk &&
                        (fifo_lv[0] == '0) && (fifo_lv[1] == '0) && (fifo_lv[2] == '0) &&
                        (dn_isdq_reg == '0) && (dn_idct_reg == '0);

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    pic_pend_next = picture_done ? picture_complete : (pic_pend_reg || picture_complete);
    case (state_reg)
      ST_IDLE: begin
        if (mb_accept) begin
          state_next = ST_BLK;
          idx_next   = '0;
        end
      end
      default: begin
        if (ev_be) begin
          if (idx_reg == LAST_BLK) state_next = ST_IDLE;
          else                     idx_next   = idx_reg + 3'd1;
        end
      end
    endcase
  end

  function automatic logic [CW-1:0] updn(input logic [CW-1:0] v, input logic inc, input logic dec);
    case ({inc, dec})
      2'b10:   return v + 1'b1;
      2'b01:   return v - 1'b1;
      default: return v;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      idx_reg      <= '0;
      cbp_reg      <= '0;
      intra_reg    <= 1'b0;
      dn_isdq_reg  <= '0;
      dn_idct_reg  <= '0;
      pic_pend_reg <= 1'b0;
    end else if (softreset) begin
      state_reg    <= ST_IDLE;
      idx_reg      <= '0;
      cbp_reg      <= '0;
      intra_reg    <= 1'b0;
      dn_isdq_reg  <= '0;
      dn_idct_reg  <= '0;
      pic_pend_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      if (mb_accept) begin
        cbp_reg   <= mb_cbp;
        intra_reg <= mb_intra;
      end
      dn_isdq_reg  <= updn(dn_isdq_reg, ev_isdq, idct_start);
      dn_idct_reg  <= updn(dn_idct_reg, ev_idct, mc_start);
      pic_pend_reg <= pic_pend_next;
    end
  end

endmodule

// File: tb/tb_m2vblkseq.sv
// Randomized bench for m2vblkseq: acts as m2vctrl and the downstream stages, and
// checks every output each cycle against a queue-based model of the block flow.
module tb_m2vblkseq;

  localparam int D = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       softreset = 1'b0;
  logic       mb_valid = 1'b0;
  logic [5:0] mb_cbp = '0;
  logic       mb_intra = 1'b0;
  logic       block_start = 1'b0;
  logic       block_end = 1'b0;
  logic       picture_complete = 1'b0;
  logic       isdq_done = 1'b0;
  logic       idct_done = 1'b0;
  logic       mc_done = 1'b0;
  logic       mb_ready, s1_coded, ready_isdq, ready_idct, ready_mc;
  logic       idct_start, mc_start, mc_mb_last, picture_done, err;
  logic [2:0] s1_block;
  logic [3:0] idct_block, mc_block;

  always #5 clk = ~clk;

  m2vblkseq #(.BUF_DEPTH(D)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .softreset        (softreset),
    .mb_valid         (mb_valid),
    .mb_cbp           (mb_cbp),
    .mb_intra         (mb_intra),
    .mb_ready         (mb_ready),
    .s1_block         (s1_block),
    .s1_coded         (s1_coded),
    .block_start      (block_start),
    .block_end        (block_end),
    .picture_complete (picture_complete),
    .isdq_done        (isdq_done),
    .idct_done        (idct_done),
    .mc_done          (mc_done),
    .ready_isdq       (ready_isdq),
    .ready_idct       (ready_idct),
    .ready_mc         (ready_mc),
    .idct_start       (idct_start),
    .idct_block       (idct_block),
    .mc_start         (mc_start),
    .mc_block         (mc_block),
    .mc_mb_last       (mc_mb_last),
    .picture_done     (picture_done),
    .err              (err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: macroblock walk plus tag queues for the three stage buffers
  bit         m_busy;
  int         m_idx;
  bit [5:0]   m_cbp;
  bit         m_intra;
  logic [3:0] qa[$], qb[$], qc[$];
  int         dn_i, dn_d;
  bit         m_pend, m_err;
  int         pd_count;

  // Stimulus agent state
  bit started, hold_mc, want_pic;
  int mbs_left, desc_n;

  function automatic bit e_coded();
    return m_intra || m_cbp[5 - m_idx];
  endfunction
  function automatic bit e_idct_start();
    return (dn_i > 0) && (qb.size() < D);
  endfunction
  function automatic bit e_mc_start();
    return (dn_d > 0) && (qc.size() < D);
  endfunction
  function automatic bit e_pdone();
    return m_pend && !m_busy && qa.size() == 0 && qb.size() == 0 && qc.size() == 0 &&
           dn_i == 0 && dn_d == 0;
  endfunction

  task automatic model_clear();
    m_busy = 0; m_idx = 0; m_cbp = '0; m_intra = 0;
    qa.delete(); qb.delete(); qc.delete();
    dn_i = 0; dn_d = 0; m_pend = 0; m_err = 0;
    started = 0; mbs_left = 0; want_pic = 0;
  endtask

  task automatic check_outputs();
    bit e_last;
    e_last = e_mc_start() && qb.size() > 0 && qb[0][2:0] == 3'd5;
    check_eq("mb_ready", 32'(mb_ready), 32'(!m_busy));
    if (m_busy) begin
      check_eq("s1_block", 32'(s1_block), 32'(m_idx));
      check_eq("s1_coded", 32'(s1_coded), 32'(e_coded()));
    end
    check_eq("ready_isdq", 32'(ready_isdq), 32'(qa.size() < D));
    check_eq("ready_idct", 32'(ready_idct), 32'(qb.size() < D));
    check_eq("ready_mc", 32'(ready_mc), 32'(qc.size() < D));
    check_eq("idct_start", 32'(idct_start), 32'(e_idct_start()));
    check_eq("mc_start", 32'(mc_start), 32'(e_mc_start()));
    if (e_idct_start()) check_eq("idct_block", 32'(idct_block), 32'(qa[0]));
    if (e_mc_start())   check_eq("mc_block", 32'(mc_block), 32'(qb[0]));
    check_eq("mc_mb_last", 32'(mc_mb_last), 32'(e_last));
    check_eq("picture_done", 32'(picture_done), 32'(e_pdone()));
    check_eq("err", 32'(err), 32'(m_err));
  endtask

  task automatic clear_inputs();
    mb_valid = 0; block_start = 0; block_end = 0; picture_complete = 0;
    isdq_done = 0; idct_done = 0; mc_done = 0;
  endtask

  // Advance the model by one clock given the inputs currently driven.
  task automatic model_update();
    bit ei, em, pd;
    logic [3:0] tag;
    ei  = e_idct_start();
    em  = e_mc_start();
    pd  = e_pdone();
    tag = {e_coded(), 3'(m_idx)};
    if (softreset) begin
      model_clear();
      return;
    end
    if (pd) pd_count++;
    if (mc_done && qc.size() > 0) void'(qc.pop_front());
    if (em) begin qc.push_back(qb.pop_front()); dn_d--; end
    if (ei) begin qb.push_back(qa.pop_front()); dn_i--; end
    if (block_start && m_busy) qa.push_back(tag);
    if (isdq_done) dn_i++;
    if (idct_done) dn_d++;
    if (!m_busy && mb_valid) begin
      m_busy = 1; m_idx = 0; m_cbp = mb_cbp; m_intra = mb_intra;
    end else if (m_busy && block_end) begin
      if (m_idx == 5) m_busy = 0;
      else            m_idx++;
    end
    m_pend = pd ? picture_complete : (m_pend || picture_complete);
  endtask

  task automatic drive_random();
    clear_inputs();
    if (!m_busy && mbs_left > 0 && $urandom_range(0, 3) == 0) begin
      mb_valid = 1;
      if (desc_n == 0)      begin mb_cbp = 6'b000000; mb_intra = 1; end
      else if (desc_n == 1) begin mb_cbp = 6'b100001; mb_intra = 0; end
      else begin mb_cbp = 6'($urandom); mb_intra = ($urandom_range(0, 3) == 0); end
      $display("[TB] mb %0d accepted cbp=%b intra=%0d", desc_n, mb_cbp, mb_intra);
      desc_n++;
      mbs_left--;
      started = 0;
    end else if (m_busy) begin
      if (!started && qa.size() < D && $urandom_range(0, 1) == 0) begin
        block_start = 1; started = 1;
      end else if (started && $urandom_range(0, 2) == 0) begin
        block_end = 1; started = 0;
      end
    end
    if (want_pic && mbs_left == 0 && !m_busy) begin
      picture_complete = 1; want_pic = 0;
    end
    if (qa.size() > dn_i && $urandom_range(0, 1) == 0) isdq_done = 1;
    if (qb.size() > dn_d && $urandom_range(0, 1) == 0) idct_done = 1;
    if (!hold_mc && qc.size() > 0 && $urandom_range(0, 1) == 0) mc_done = 1;
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    drive_random();
    model_update();
  endtask

  task automatic run_picture(input int n_mb, input int hold_cycles);
    int start_pd, k;
    start_pd = pd_count;
    mbs_left = n_mb;
    want_pic = 1;
    k = 0;
    while (pd_count == start_pd && k < 4000) begin
      hold_mc = (k < hold_cycles);
      if (k == hold_cycles && hold_cycles > 0 && qc.size() == D) begin
        @(negedge clk);
        check_eq("mc_stall_ready_mc", 32'(ready_mc), 32'(0));
        check_eq("mc_stall_mc_start", 32'(mc_start), 32'(0));
        drive_random();
        model_update();
      end else begin
        step();
      end
      k++;
    end
    hold_mc = 0;
    if (pd_count == start_pd) check_eq("picture_drain_timeout", 32'(0), 32'(1));
    step();
    $display("[TB] picture of %0d mb drained after %0d cycles", n_mb, k);
  endtask

  task automatic do_softreset();
    @(negedge clk);
    check_outputs();
    drive_random();
    softreset = 1;
    model_update();
    @(negedge clk);
    softreset = 0;
    check_outputs();
    check_eq("srst_mb_ready", 32'(mb_ready), 32'(1));
    check_eq("srst_s1_block", 32'(s1_block), 32'(0));
    check_eq("srst_s1_coded", 32'(s1_coded), 32'(0));
    check_eq("srst_idct_block", 32'(idct_block), 32'(0));
    check_eq("srst_mc_block", 32'(mc_block), 32'(0));
    check_eq("srst_err", 32'(err), 32'(0));
    clear_inputs();
    $display("[TB] softreset applied");
  endtask

  initial begin
    int k;
    model_clear();
    pd_count = 0;
    desc_n   = 0;
    hold_mc  = 0;

    repeat (2) @(negedge clk);
    check_outputs();
    check_eq("rst_idct_block", 32'(idct_block), 32'(0));
    check_eq("rst_mc_block", 32'(mc_block), 32'(0));
    check_eq("rst_s1_block", 32'(s1_block), 32'(0));
    reset_n = 1;

    run_picture(2, 0);
    run_picture(1, 200);
    run_picture(3, 40);

    // Softreset in the middle of a macroblock
    mbs_left = 2;
    k = 0;
    while (!(m_busy && m_idx >= 2) && k < 1000) begin step(); k++; end
    if (k == 1000) check_eq("softreset_setup_timeout", 32'(0), 32'(1));
    do_softreset();

    run_picture(2, 0);

`ifdef M2VBLKSEQ_ERRCHK_EN
    @(negedge clk);
    check_outputs();
    clear_inputs();
    mc_done = 1;
    model_update();
    m_err = 1;
    @(negedge clk);
    check_eq("err_mc_empty", 32'(err), 32'(1));
    check_eq("err_ready_mc_unchanged", 32'(ready_mc), 32'(1));
    check_outputs();
    clear_inputs();
    block_end = 1;
    model_update();
    @(negedge clk);
    check_eq("err_sticky", 32'(err), 32'(1));
    check_eq("err_blkend_idle_mb_ready", 32'(mb_ready), 32'(1));
    clear_inputs();
    do_softreset();
`endif

    for (int p = 0; p < 4; p++) run_picture(1 + p % 3, (p == 2) ? 60 : 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
